comp_vector_gen: RTL

Exhaustive stimulus generator and result checker for the W-bit equality comparators (one-bit and two-bit equality units and their wider compositions). It drives every operand pair (a, b) into a comparator under test, one pair per clock. It samples the comparator's equality output, checks it against the golden result a == b, and reports an error count, the first failing pair and a pass flag. It is the driving/checking end of the comparator interface and is used in on-board self-test and in benches.

---
 rtl/comp_vector_gen_if.sv | 29 ++
 rtl/comp_vector_gen.sv | 121 ++++++++++++
 2 files changed

// File: rtl/comp_vector_gen_if.sv
// Comparator self-test bus: operand pairs out, equality result back, sweep status.
// master = generator/checker end, slave = comparator/observer end.
interface comp_vector_gen_if #(parameter int W = 2);
  logic             start;
  logic             hold;
  logic             eq_in;
  logic [W-1:0]     a_out;
  logic [W-1:0]     b_out;
  logic             valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic [2*W:0]     err_count;
  logic [W-1:0]     first_err_a;
  logic [W-1:0]     first_err_b;
  logic             err_seen;

  modport master (
    input  start, hold, eq_in,
    output a_out, b_out, valid, busy, done, pass,
           err_count, first_err_a, first_err_b, err_seen
  );

  modport slave (
    output start, hold, eq_in,
    input  a_out, b_out, valid, busy, done, pass,
           err_count, first_err_a, first_err_b, err_seen
  );
endinterface

// File: rtl/comp_vector_gen.sv
// Exhaustive a-major operand sweep for a W-bit equality comparator,
// checking eq_in against a == b and reporting error count / first failure.
module comp_vector_gen #(
  parameter int W = 2
) (
  input  logic              clk,
  input  logic              reset,
  comp_vector_gen_if.master bus
);
  localparam int CW = 2*W + 1;
  localparam logic [W-1:0] ONES = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, n_state;
  logic [W-1:0]    a, n_a, b, n_b, fa, n_fa, fb, n_fb;
  logic [CW-1:0]   cnt, n_cnt;
  logic            valid, n_valid, busy, n_busy, done, n_done;
  logic            pass, n_pass, seen, n_seen;
  logic            mism;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      fa    <= '0;
      fb    <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      seen  <= 1'b0;
    end else begin
      state <= n_state;
      a     <= n_a;
      b     <= n_b;
      fa    <= n_fa;
      fb    <= n_fb;
      cnt   <= n_cnt;
      valid <= n_valid;
      busy  <= n_busy;
      done  <= n_done;
      pass  <= n_pass;
      seen  <= n_seen;
    end
  end

  always_comb begin
    n_state = state;
    n_a     = a;
    n_b     = b;
    n_fa    = fa;
    n_fb    = fb;
    n_cnt   = cnt;
    n_valid = valid;
    n_busy  = busy;
    n_done  = 1'b0;
    n_pass  = pass;
    n_seen  = seen;
    mism    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          n_state = RUN;
          n_a     = '0;
          n_b     = '0;
          n_fa    = '0;
          n_fb    = '0;
          n_cnt   = '0;
          n_seen  = 1'b0;
          n_pass  = 1'b0;
          n_valid = 1'b1;
          n_busy  = 1'b1;
        end
      end
      RUN: begin
        // valid is registered, so hold gates the next cycle; a pair already
        // presented with valid=1 is checked and retired at this edge.
        n_valid = !bus.hold;
        if (valid) begin
          mism = bus.eq_in != (a == b);
          if (mism) begin
            n_cnt = cnt + CW'(1);
            if (!seen) begin
              n_fa   = a;
              n_fb   = b;
              n_seen = 1'b1;
            end
          end
          if (a == ONES && b == ONES) begin
            n_state = DONE;
            n_valid = 1'b0;
            n_busy  = 1'b0;
            n_done  = 1'b1;
            n_pass  = (n_cnt == '0);
            n_a     = '0;
            n_b     = '0;
          end else begin
            n_b = b + W'(1);
            if (b == ONES) n_a = a + W'(1);
          end
        end
      end
      DONE:    n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end

  assign bus.a_out       = a;
  assign bus.b_out       = b;
  assign bus.valid       = valid;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.pass        = pass;
  assign bus.err_count   = cnt;
  assign bus.first_err_a = fa;
  assign bus.first_err_b = fb;
  assign bus.err_seen    = seen;
endmodule
